shift_mult_ctrl: RTL
====================

Name: shift_mult_ctrl

Overview:
- Sequencer for a shift-and-add unsigned multiplier. It drives an external 8-bit right-shift register that holds the multiplier.
- The shift register has synchronous active-high clear, synchronous load, and shifts right on every clock when neither clear nor load is asserted. clear has priority over load.
- This block accepts operands through a start/busy/done handshake and loads the shift register. It then lets the register shift for WIDTH cycles, samples the register's LSB each cycle, and accumulates the partial products into a 2*WIDTH product register.

Parameters:
- WIDTH, 8, operand width. Must equal the external shift register width.
- CNT_W, 4, bit-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request a multiply; sampled only in IDLE.
- abort  input  1  synchronous cancel; effective in LOAD or RUN.
- multiplicand  input  WIDTH  operand A; captured on accepted start.
- multiplier  input  WIDTH  operand B; captured on accepted start.
- sr_lsb  input  1  bit 0 of the external shift register output.
- sr_clear  output  1  drives the shift register's clear.
- sr_load  output  1  drives the shift register's load.
- sr_in  output  WIDTH  parallel load data for the shift register.
- busy  output  1  high in LOAD and RUN.
- done  output  1  single-cycle pulse in DONE.
- product  output  2*WIDTH  result; held until the next accepted start.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, count=0, accumulator=0, product=0.
  - mcand_reg=0, mplier_reg=0, done=0, busy=0.
  - sr_clear=1, sr_load=0, sr_in=0.
- All outputs are decoded from registered state only; no combinational path from inputs to outputs.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Outputs: sr_clear=1, sr_load=0. This holds the shift register at 0.
  - On start=1: capture multiplicand into mcand_reg and multiplier into mplier_reg; clear accumulator; count=0; go to LOAD.
  - On start=0: stay in IDLE.
- LOAD (1 cycle):
  - Outputs: sr_clear=0, sr_load=1, sr_in=mplier_reg, busy=1.
  - Next state RUN; the shift register holds the multiplier after this edge.
  - abort=1 goes to IDLE instead.
- RUN (exactly WIDTH cycles; count runs 0..WIDTH-1):
  - Outputs: sr_clear=0, sr_load=0, busy=1. The register shifts every cycle, so sr_lsb in RUN cycle k equals multiplier bit k.
  - Each cycle: if sr_lsb=1, accumulator += zero-extended mcand_reg << count. Addition is 2*WIDTH wide; it cannot overflow because max is (2^W-1)^2.
  - count increments each cycle.
  - When count==WIDTH-1: after the final add, go to DONE and copy the final sum into product on that same edge.
  - abort=1 in any RUN cycle: go to IDLE; product unchanged; no done pulse; accumulator discarded.
- DONE (1 cycle):
  - Outputs: done=1, busy=0, sr_clear=1.
  - Next state IDLE unconditionally.
  - start is ignored in DONE.
- Latency: start accepted at edge E0. LOAD is the cycle after E0, RUN is the next WIDTH cycles, DONE is the cycle after that. done is high WIDTH+2 cycles after the accept edge (10 for WIDTH=8).
- Throughput: next accept no earlier than the IDLE cycle after DONE. One operation per WIDTH+3 cycles.
- start while busy: ignored, not queued. Operand inputs are don't-care outside the accept cycle.
- abort outside LOAD/RUN: ignored.
- start and abort both high in IDLE: start wins; abort is ignored in IDLE.
- Reset asserted mid-operation: immediate return to IDLE, product=0, sr_clear=1 on the next clock so the register zeroes.
- sr_lsb is ignored outside RUN.

Test Plan:
- Reset then start with multiplicand=13, multiplier=11 -> busy high for 9 cycles (LOAD plus 8 RUN); done pulses 10 cycles after the accept edge; product=143; sr_load high only in the LOAD cycle.
- 255×255 -> product=65025 (0xFE01). Then 0×200 -> product=0 with done still pulsed at the same latency.
- Start 7×9. Pulse start with 3×3 during RUN -> second request ignored; product=63. Then start 3×3 from IDLE -> product=9.
- Start 100×50, assert abort in RUN cycle 4 -> returns to IDLE; no done; product keeps the previous value (63 or 9); sr_clear returns to 1.
- Start 200×150, drive reset=0 asynchronously mid-RUN -> state IDLE, product=0, done=0, busy=0, sr_clear=1 with no clock edge needed. Release reset, then 2×3 -> product=6.
- Back-to-back: start held high continuously with 1×1 then 2×2 -> accepts occur exactly WIDTH+3 cycles apart; products 1 then 4.

Source files
------------

// File: rtl/shift_mult_ctrl.sv
// shift_mult_ctrl -- sequencer for a shift-and-add unsigned multiplier.
//
// Drives an external WIDTH-bit right-shift register (clear > load > shift).
// The multiplier is parallel-loaded into that register. The register then
// shifts for WIDTH cycles. Each cycle, sr_lsb selects whether the shifted
// multiplicand is added into a 2*WIDTH accumulator.
//
// Ports:
//   clk           rising-edge system clock
//   reset         asynchronous active-low reset
//   start         multiply request, sampled only in IDLE
//   abort         synchronous cancel, effective in LOAD or RUN
//   multiplicand  operand A, captured on accepted start
//   multiplier    operand B, captured on accepted start
//   sr_lsb        bit 0 of the external shift register
//   sr_clear      shift register clear (high in IDLE and DONE)
//   sr_load       shift register load (high in LOAD)
//   sr_in         shift register parallel load data
//   busy          high in LOAD and RUN
//   done          one-cycle pulse in DONE
//   product       result, held until the next accepted start
module shift_mult_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               sr_lsb,
    output logic               sr_clear,
    output logic               sr_load,
    output logic [WIDTH-1:0]   sr_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q,   state_d;
    logic [CNT_W-1:0]     count_q,   count_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;

    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_sum;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        product_d = product_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;

        // Shifted multiplicand for the bit currently at the register's LSB.
        partial = '0;
        if (sr_lsb) begin
            partial = {{WIDTH{1'b0}}, mcand_q} << count_q;
        end
        acc_sum = acc_q + partial;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = multiplicand;
                    mplier_d = multiplier;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = acc_sum;
                    count_d = count_q + CNT_W'(1);
                    // Final bit: publish the sum on the same edge as the add.
                    if (count_q == LAST_CNT) begin
                        product_d = acc_sum;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
        end
    end

    // Outputs depend only on registered state.
    assign sr_clear = (state_q == S_IDLE) || (state_q == S_DONE);
    assign sr_load  = (state_q == S_LOAD);
    assign sr_in    = (state_q == S_LOAD) ? mplier_q : '0;
    assign busy     = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign product  = product_q;

endmodule
